// File: rtl/fb_port_arbiter.sv
// -----------------------------------------------------------------------------
// fb_port_arbiter
//
// Shares one single-port framebuffer RAM between the VGA scan-out reader and
// a pixel-drawing writer. Scan-out reads always win. Writes are posted into a
// small FIFO and drain only in cycles with no read request. Any access at or
// beyond FB_SIZE is trapped: it never reaches the RAM, and it sets a sticky
// error flag.
//
// Handshake (write side): a pixel is pushed on every rising edge where
// wr_valid && wr_ready. wr_ready comes from the registered occupancy, so a
// full FIFO refuses a push even when an entry is popped on the same edge.
// The read side has no back-pressure. Every edge with rd_req=1 accepts a
// read, and that read gets exactly one rd_valid pulse two edges later.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   rd_req, rd_addr      scan-out read request and address
//   rd_data, rd_valid    read result, valid for one cycle per accepted read
//   wr_valid, wr_ready   writer handshake
//   wr_addr, wr_data     pixel to post
//   wr_count             FIFO occupancy (0..WFIFO_DEPTH)
//   ram_addr/we/wdata    registered RAM control
//   ram_rdata            RAM read data, one cycle after ram_addr is sampled
//   addr_err, err_clr    sticky out-of-range flag and its clear
// -----------------------------------------------------------------------------
module fb_port_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int FB_SIZE     = 76800,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         rd_req,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [$clog2(WFIFO_DEPTH):0] wr_count,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic                         ram_we,
    output logic [DATA_W-1:0]            ram_wdata,
    input  logic [DATA_W-1:0]            ram_rdata,
    output logic                         addr_err,
    input  logic                         err_clr
);

    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(WFIFO_DEPTH);
    // One extra bit so the limit is representable even when FB_SIZE == 2**ADDR_W.
    localparam logic [ADDR_W:0]   FB_LIM   = (ADDR_W + 1)'(FB_SIZE);

    // Posted-write FIFO storage (no reset needed; validity comes from pointers).
    logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;

    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              rd_oor;
    logic              head_oor;
    logic              err_set;

    // Read pipeline. Stage 1 means the address is on ram_addr. Stage 2 means
    // the RAM is returning data. The bad flags replace the data with zero for
    // trapped reads.
    logic              rd_p1;
    logic              rd_p2;
    logic              rd_bad1;
    logic              rd_bad2;

    assign fifo_empty = (wr_count == '0);
    assign wr_ready   = (wr_count != FULL_CNT);
    assign push       = wr_valid && wr_ready;
    assign pop        = !rd_req && !fifo_empty;
    assign head_addr  = fifo_addr[rptr];
    assign head_data  = fifo_data[rptr];
    assign rd_oor     = ({1'b0, rd_addr} >= FB_LIM);
    assign head_oor   = ({1'b0, head_addr} >= FB_LIM);
    assign err_set    = (rd_req && rd_oor) || (pop && head_oor);

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wptr] <= wr_addr;
            fifo_data[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            wr_count <= '0;
        end else begin
            // Pointers are exactly PTR_W bits wide, so they wrap modulo depth.
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   wr_count <= wr_count + 1'b1;
                2'b01:   wr_count <= wr_count - 1'b1;
                default: wr_count <= wr_count;
            endcase
        end
    end

    // RAM port arbitration: read wins, else drain one write, else idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            ram_we <= 1'b0;
            if (rd_req) begin
                if (!rd_oor) ram_addr <= rd_addr;
            end else if (pop) begin
                if (!head_oor) begin
                    ram_addr  <= head_addr;
                    ram_wdata <= head_data;
                    ram_we    <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_p1    <= 1'b0;
            rd_p2    <= 1'b0;
            rd_bad1  <= 1'b0;
            rd_bad2  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_p1    <= rd_req;
            rd_bad1  <= rd_req && rd_oor;
            rd_p2    <= rd_p1;
            rd_bad2  <= rd_bad1;
            rd_valid <= rd_p2;
            if (rd_p2) rd_data <= rd_bad2 ? '0 : ram_rdata;
        end
    end

    // Sticky error flag. A new error takes priority over a clear on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else if (err_set) begin
            addr_err <= 1'b1;
        end else if (err_clr) begin
            addr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [2:0]        wr_count;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              addr_err;
  logic              err_clr;

  // Back-door write port into the RAM model for preloading single words.
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [DATA_W-1:0] bd_data;

  int errors = 0;
  int checks = 0;

  fb_port_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_count  (wr_count),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .addr_err  (addr_err),
    .err_clr   (err_clr)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // Synchronous single-port RAM model. Words never written read as addr[7:0].
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  bit                written [1 << ADDR_W];

  always @(posedge clock) begin
    if (bd_we) begin
      mem[bd_addr]     <= bd_data;
      written[bd_addr] <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : ram_addr[7:0];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0;
    wr_data = '0; err_clr = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // ---- reset state
    tick(); tick();
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_wdata", 32'(ram_wdata), 0);
    check("rst_addr_err", 32'(addr_err), 0);
    reset = 1'b0;

    // ---- back-to-back reads of 0,1,2: results at edges k+2..k+4
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin rd_req = 1'b1; rd_addr = 17'(i); end
      else rd_req = 1'b0;
      tick();
      check("r3_ram_we", 32'(ram_we), 0);
      if (i < 2) check("r3_valid_early", 32'(rd_valid), 0);
      else if (i < 5) begin
        check("r3_valid", 32'(rd_valid), 1);
        check("r3_data", 32'(rd_data), 32'(i - 2));
      end else check("r3_valid_end", 32'(rd_valid), 0);
      if (i < 3) check("r3_ram_addr", 32'(ram_addr), 32'(i));
    end

    // ---- four posted writes to 10..13 drain while rd_req is low
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 17'(10 + i); wr_data = 8'(8'hA0 + i);
      tick();
      check("w4_count", 32'(wr_count), 1);
      if (i == 0) check("w4_we_first", 32'(ram_we), 0);
      else begin
        check("w4_we", 32'(ram_we), 1);
        check("w4_addr", 32'(ram_addr), 32'(10 + i - 1));
        check("w4_wdata", 32'(ram_wdata), 32'(8'hA0 + i - 1));
      end
    end
    wr_valid = 1'b0;
    tick();
    check("w4_last_we", 32'(ram_we), 1);
    check("w4_last_addr", 32'(ram_addr), 13);
    check("w4_last_wdata", 32'(ram_wdata), 32'hA3);
    check("w4_count_empty", 32'(wr_count), 0);
    tick();
    check("w4_idle_we", 32'(ram_we), 0);
    check("w4_idle_addr_hold", 32'(ram_addr), 13);

    // read back 10..13
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin rd_req = 1'b1; rd_addr = 17'(10 + i); end
      else rd_req = 1'b0;
      tick();
      if (i >= 2) begin
        check("rb_valid", 32'(rd_valid), 1);
        check("rb_data", 32'(rd_data), 32'(8'hA0 + i - 2));
      end
    end

    // ---- FIFO fills under continuous reads, then drains
    rd_req = 1'b1; rd_addr = '0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 17'(20 + i); wr_data = 8'(8'hB0 + i);
      tick();
      check("fill_count", 32'(wr_count), 32'(i + 1));
      check("fill_we", 32'(ram_we), 0);
    end
    check("full_ready", 32'(wr_ready), 0);
    wr_addr = 17'd24; wr_data = 8'hB4;
    tick();
    check("full_refuse_count", 32'(wr_count), 4);
    check("full_refuse_we", 32'(ram_we), 0);
    rd_req = 1'b0;
    tick();  // pop 20, push refused (was full)
    check("drain0_count", 32'(wr_count), 3);
    check("drain0_we", 32'(ram_we), 1);
    check("drain0_addr", 32'(ram_addr), 20);
    check("drain0_ready", 32'(wr_ready), 1);
    tick();  // push 24, pop 21
    wr_valid = 1'b0;
    check("drain1_count", 32'(wr_count), 3);
    check("drain1_addr", 32'(ram_addr), 21);
    for (int i = 2; i < 5; i++) begin
      tick();
      check("drain_we", 32'(ram_we), 1);
      check("drain_addr", 32'(ram_addr), 32'(20 + i));
      check("drain_wdata", 32'(ram_wdata), 32'(8'hB0 + i));
      check("drain_count", 32'(wr_count), 32'(4 - i));
    end
    tick();
    check("drain_done_we", 32'(ram_we), 0);

    // ---- out-of-range read
    rd_req = 1'b1; rd_addr = 17'd76800;
    tick();
    rd_req = 1'b0;
    check("oor_rd_addr_hold", 32'(ram_addr), 24);
    check("oor_rd_err", 32'(addr_err), 1);
    tick();
    check("oor_rd_valid_early", 32'(rd_valid), 0);
    tick();
    check("oor_rd_valid", 32'(rd_valid), 1);
    check("oor_rd_data", 32'(rd_data), 0);
    tick();
    check("oor_err_sticky", 32'(addr_err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 32'(addr_err), 0);

    // ---- out-of-range write: consumed without ram_we
    wr_valid = 1'b1; wr_addr = 17'd100000; wr_data = 8'h77;
    tick();
    wr_valid = 1'b0;
    check("oor_wr_count", 32'(wr_count), 1);
    tick();
    check("oor_wr_count_pop", 32'(wr_count), 0);
    check("oor_wr_we", 32'(ram_we), 0);
    check("oor_wr_addr_hold", 32'(ram_addr), 24);
    check("oor_wr_err", 32'(addr_err), 1);
    err_clr = 1'b1;
    tick();
    check("err_cleared2", 32'(addr_err), 0);
    // set wins over clear on the same edge
    rd_req = 1'b1; rd_addr = 17'd80000;
    tick();
    rd_req = 1'b0; err_clr = 1'b0;
    check("err_set_wins", 32'(addr_err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared3", 32'(addr_err), 0);
    tick(); tick();

    // ---- reset with reads in flight and 3 queued writes
    rd_req = 1'b1; rd_addr = 17'd3;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 17'(30 + i); wr_data = 8'(8'hC0 + i);
      tick();
    end
    wr_valid = 1'b0;
    check("pre_rst_count", 32'(wr_count), 3);
    rd_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("flush_valid", 32'(rd_valid), 0);
    check("flush_count", 32'(wr_count), 0);
    check("flush_we", 32'(ram_we), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_valid", 32'(rd_valid), 0);
      check("flush_no_we", 32'(ram_we), 0);
    end

    // ---- no forwarding from pending writes
    bd_we = 1'b1; bd_addr = 17'd5; bd_data = 8'h11;
    tick();
    bd_we = 1'b0;
    rd_req = 1'b1; rd_addr = 17'd5;
    wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 8'h55;
    tick();
    wr_valid = 1'b0;
    tick();
    rd_req = 1'b0;
    tick();
    check("nofwd_valid", 32'(rd_valid), 1);
    check("nofwd_data", 32'(rd_data), 32'h11);
    check("nofwd_drain_we", 32'(ram_we), 1);
    check("nofwd_drain_addr", 32'(ram_addr), 5);
    tick();
    check("nofwd_data2", 32'(rd_data), 32'h11);
    rd_req = 1'b1; rd_addr = 17'd5;
    tick();
    rd_req = 1'b0;
    tick(); tick();
    check("after_drain_valid", 32'(rd_valid), 1);
    check("after_drain_data", 32'(rd_data), 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port framebuffer RAM between two requesters.
- Requester one is the VGA scan-out path: pixel reads at the addresses produced by the address generator.
- Requester two is a pixel-drawing writer, with its writes posted into a small FIFO.
- Scan-out reads have absolute priority. Writes drain only in cycles with no read request. Out-of-range addresses are trapped.

Parameters:
ADDR_W, 17, framebuffer address width
DATA_W, 8, pixel data width
FB_SIZE, 76800, number of valid pixel locations (320x240); legal addresses are 0..FB_SIZE-1
WFIFO_DEPTH, 4, write FIFO entries (power of two, >=2)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
rd_req  in  1  scan-out read request, sampled every edge
rd_addr  in  ADDR_W  scan-out read address
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data valid, one cycle per accepted read
wr_valid  in  1  writer has a pixel to post
wr_ready  out  1  FIFO can accept (not full)
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write pixel
wr_count  out  $clog2(WFIFO_DEPTH)+1  FIFO occupancy
ram_addr  out  ADDR_W  registered RAM address
ram_we  out  1  registered RAM write enable
ram_wdata  out  DATA_W  registered RAM write data
ram_rdata  in  DATA_W  RAM read data, one cycle after ram_addr is sampled
addr_err  out  1  sticky flag: out-of-range access seen
err_clr  in  1  clears addr_err

Behaviour:
- Reset (synchronous): FIFO emptied (wr_count=0, wr_ready=1). rd_valid=0, rd_data=0, ram_addr=0, ram_we=0, ram_wdata=0, addr_err=0. In-flight read results are discarded and rd_valid is not asserted for them.
- Write push: occurs on an edge where wr_valid && wr_ready.
  - wr_ready = (wr_count != WFIFO_DEPTH), driven from registered count.
  - When full, a pop in the same cycle does not allow a same-cycle push (no pass-through).
- Arbitration, evaluated each edge (no internal state machine beyond FIFO pointers and read pipeline):
  - READ: rd_req=1. ram_addr<=rd_addr, ram_we<=0. FIFO not popped.
  - WRITE: rd_req=0 and FIFO not empty. Pop head; ram_addr<=head.addr, ram_wdata<=head.data, ram_we<=1.
  - IDLE: neither applies. ram_we<=0; ram_addr holds.
- Read latency:
  - Read accepted at edge k: rd_valid=1 and rd_data=ram_rdata registered at edge k+2.
  - Back-to-back reads sustain one result per cycle, in order.
- Simultaneous push and pop: wr_count unchanged; FIFO order preserved.
- No forwarding: a read to an address with a pending FIFO write returns the old RAM content.
- Range check, addr >= FB_SIZE:
  - Read: ram_addr is not driven with it (held). Request still yields rd_valid at k+2 with rd_data=0. addr_err<=1.
  - Write: entry is popped but ram_we<=0. addr_err<=1.
- addr_err: sticky. err_clr=1 clears it. If a new error and err_clr occur in the same cycle, set wins.
- wr_count arithmetic: wraps never. Pointers are log2(WFIFO_DEPTH) bits and wrap modulo depth.
- Starvation: continuous rd_req starves writes indefinitely. This is by design; the writer must rely on blanking intervals.

Test Plan:
- Reset then rd_req=1 with rd_addr=0, 1, 2 on consecutive edges, RAM preloaded with data=addr[7:0] -> rd_valid high for 3 cycles starting 2 edges after the first accept, rd_data=0x00, 0x01, 0x02, ram_we=0 throughout.
- rd_req=0; post 4 writes (addr 10..13, data 0xA0..0xA3) back-to-back -> wr_count peaks ≤4. ram_we pulses with ram_addr=10..13 in order. RAM reads back 0xA0..0xA3.
- Hold rd_req=1 and post 5 writes -> wr_ready drops after the 4th, wr_count=4, no ram_we. Drop rd_req -> 4 consecutive writes drain, wr_ready returns high, 5th write accepted and drained.
- Read at addr 76800 and write at addr 100000 -> read yields rd_valid with rd_data=0. Write is consumed with ram_we=0. addr_err=1 and stays 1 until err_clr pulse, then 0.
- Assert reset while 2 reads are in flight and FIFO holds 3 entries -> the next cycle has rd_valid=0, wr_count=0, ram_we=0, and no later rd_valid for the flushed reads.
- Pending write to addr 5 (0x55) with RAM holding 0x11 while rd_req=1 reads addr 5 -> rd_data=0x11. After rd_req drops and the write drains, a read of addr 5 returns 0x55.
